fifo_rd_adapter: RTL and testbench

- Read-side consumer placed directly downstream of the FIFO, on the same FIFO_Interface signals the monitor samples.
- Converts the FIFO's rd_en/data_out port, whose data_out is registered with one-cycle read latency, into a valid/ready stream.
- Never underflows the FIFO and sustains one word per cycle.
- Provides a forwarded-word counter and a sticky underflow error flag for the bench and scoreboard.

---
 rtl/fifo_rd_adapter_pkg.sv | 11 +
 rtl/fifo_rd_adapter_chk.sv | 21 ++
 rtl/fifo_rd_adapter_rd_skid_buf.sv | 55 +++++
 rtl/fifo_rd_adapter.sv | 99 +++++++++
 tb/tb_fifo_rd_adapter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_adapter_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
// Widths here must stay in step with the FIFO shared package.
package fifo_rd_adapter_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_BUF_DEPTH  = 2;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_adapter_chk.sv
// Structural invariants of the read adapter, kept out of the datapath.
module fifo_rd_adapter_chk
  import fifo_rd_adapter_pkg::*;
#(
  parameter int DEPTH = DEF_BUF_DEPTH,
  parameter int CW    = $clog2(DEF_BUF_DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic [CW-1:0] count
);

  // The credit rule must never let a captured word land on a full buffer
  always @(posedge clk) begin
    if (!rst && push) begin
      assert (count < CW'(DEPTH));
    end
  end

endmodule

// File: rtl/fifo_rd_adapter_rd_skid_buf.sv
// Small circular output buffer with push/pop, occupancy count and a
// valid/data head view; shared by the read- and write-side adapters.
module rd_skid_buf
  import fifo_rd_adapter_pkg::*;
#(
  parameter int WIDTH = DEF_FIFO_WIDTH,
  parameter int DEPTH = DEF_BUF_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;

  // Storage, pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count   = count_r;
  assign m_valid = (count_r != CW'(0));
  assign m_data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Turns the FIFO's one-cycle-latency rd_en/data_out port into a
// valid/ready stream, with a forwarded-word counter and sticky underflow flag.
module fifo_rd_adapter
  import fifo_rd_adapter_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  fwd_count,
  output logic                  underflow_err
);

  localparam int            CW        = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(BUF_DEPTH);

  logic                 pend_r;
  logic [CW-1:0]        buf_count_s;
  logic                 pop_s;
  logic [CW:0]          occ_s;
  logic [CW:0]          occ_after_pop_s;
  logic                 rd_en_s;
  logic [CNT_WIDTH-1:0] fwd_count_r;
  logic                 underflow_err_r;

  assign pop_s = m_valid && m_ready;

  // Issue a read only when the returning word is guaranteed a buffer slot
  always_comb begin
    occ_s           = {1'b0, buf_count_s} + {{CW{1'b0}}, pend_r};
    occ_after_pop_s = occ_s - {{CW{1'b0}}, pop_s};
    if (!rst && enable && !fifo_empty && (occ_after_pop_s < DEPTH_LIM)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  assign fifo_rd_en = rd_en_s;

  // In-flight tracking, forwarded-word count and sticky underflow
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r          <= 1'b0;
      fwd_count_r     <= CNT_WIDTH'(0);
      underflow_err_r <= 1'b0;
    end else begin
      pend_r <= rd_en_s;
      if (pop_s) begin
        fwd_count_r <= fwd_count_r + CNT_WIDTH'(1);
      end else begin
        fwd_count_r <= fwd_count_r;
      end
      if (fifo_underflow) begin
        underflow_err_r <= 1'b1;
      end else begin
        underflow_err_r <= underflow_err_r;
      end
    end
  end

  rd_skid_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_r),
    .push_data (fifo_data_out),
    .pop       (pop_s),
    .count     (buf_count_s),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

  fifo_rd_adapter_chk #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_r),
    .count (buf_count_s)
  );

  assign fwd_count     = fwd_count_r;
  assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: a behavioural FIFO feeds the adapter, and a
// word-order scoreboard plus counter/flag model check the stream side.
module tb_fifo_rd_adapter;
  import fifo_rd_adapter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty;
  fifo_word_t  fifo_data_out = 16'h0000;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  fifo_word_t  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] fwd_count;
  logic        underflow_err;

  always #5 clk = ~clk;

  fifo_rd_adapter dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .fwd_count      (fwd_count),
    .underflow_err  (underflow_err)
  );

  // Behavioural 64-entry FIFO with registered read data
  fifo_word_t fmem [64];
  logic [5:0] fwp = 6'd0;
  logic [5:0] frp = 6'd0;
  logic [6:0] fcnt = 7'd0;
  logic       uf_r = 1'b0;
  logic       uf_force = 1'b0;
  logic       wr_req = 1'b0;
  fifo_word_t wr_data = 16'h0000;
  logic       rd_ok, wr_ok;

  assign fifo_empty     = (fcnt == 7'd0);
  assign fifo_underflow = uf_r | uf_force;
  assign rd_ok          = fifo_rd_en && !fifo_empty;
  assign wr_ok          = wr_req && (fcnt != 7'd64);

  always @(posedge clk) begin
    if (rst) begin
      fwp <= 6'd0; frp <= 6'd0; fcnt <= 7'd0; uf_r <= 1'b0;
    end else begin
      if (wr_ok) begin fmem[fwp] <= wr_data; fwp <= fwp + 6'd1; end
      if (rd_ok) begin fifo_data_out <= fmem[frp]; frp <= frp + 6'd1; end
      uf_r <= fifo_rd_en && fifo_empty;
      fcnt <= fcnt + {6'd0, wr_ok} - {6'd0, rd_ok};
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: words leave in FIFO write order; count pops; sticky flag
  fifo_word_t  exp_q[$];
  logic        mon_on = 1'b0;
  logic [15:0] model_cnt = 16'd0;
  logic        uf_model = 1'b0;
  logic        stall_prev = 1'b0;
  fifo_word_t  held = 16'h0000;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check_eq("fwd_count", {16'd0, fwd_count}, {16'd0, model_cnt});
        check_eq("underflow_err", {31'd0, underflow_err}, {31'd0, uf_model});
        check_eq("rd_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
        if (stall_prev) begin
          check_eq("hold_valid", {31'd0, m_valid}, 32'd1);
          check_eq("hold_data", {16'd0, m_data}, {16'd0, held});
        end
        if (rst) begin
          exp_q.delete();
          model_cnt  = 16'd0;
          uf_model   = 1'b0;
          stall_prev = 1'b0;
        end else begin
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
              check_eq("extra_word", {16'd0, m_data}, 32'hFFFF_FFFF);
            end else begin
              check_eq("data_order", {16'd0, m_data}, {16'd0, exp_q[0]});
              void'(exp_q.pop_front());
            end
            model_cnt = model_cnt + 16'd1;
          end
          if (fifo_underflow) uf_model = 1'b1;
          stall_prev = m_valid && !m_ready;
          held       = m_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_req = 1'b0; enable = 1'b0; m_ready = 1'b0; uf_force = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic put_word(input fifo_word_t w);
    wr_req = 1'b1; wr_data = w; exp_q.push_back(w);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic load(input int n, input fifo_word_t base);
    for (int i = 0; i < n; i++) put_word(base + fifo_word_t'(i));
  endtask

  int rc, rf, rl, vc, vf, vl;

  task automatic observe(input int n);
    rc = 0; rf = -1; rl = -1; vc = 0; vf = -1; vl = -1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (fifo_rd_en) begin if (rf < 0) rf = i; rl = i; rc++; end
      if (m_valid)    begin if (vf < 0) vf = i; vl = i; vc++; end
      tick();
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    enable = 1'b1; m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && k < budget) begin
      tick();
      k++;
    end
    check_eq("drain_in_budget", {31'd0, k < budget}, 32'd1);
  endtask

  initial begin
    #(10 * 98000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick();
    do_reset();
    mon_on = 1'b1;
    #1;
    check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    tick();

    // Straight stream of 8 words
    load(8, 16'h0001);
    enable = 1'b1; m_ready = 1'b1;
    observe(14);
    check_eq("s_rd_cnt", rc, 8);
    check_eq("s_rd_first", rf, 0);
    check_eq("s_rd_last", rl, 7);
    check_eq("s_v_cnt", vc, 8);
    check_eq("s_v_first", vf, 2);
    check_eq("s_v_last", vl, 9);
    check_eq("s_fwd", {16'd0, fwd_count}, 32'd8);

    // Backpressure with 6 queued words
    do_reset();
    load(6, 16'h0010);
    enable = 1'b1;
    observe(10);
    check_eq("bp_rd_cnt", rc, 2);
    check_eq("bp_rd_first", rf, 0);
    #1;
    check_eq("bp_valid", {31'd0, m_valid}, 32'd1);
    check_eq("bp_head", {16'd0, m_data}, 32'h0010);
    check_eq("bp_rd_stop", {31'd0, fifo_rd_en}, 32'd0);
    m_ready = 1'b1;
    observe(12);
    check_eq("bp_fwd", {16'd0, fwd_count}, 32'd6);
    check_eq("bp_left", exp_q.size(), 0);

    // Single word: read once, then hold off while empty
    do_reset();
    load(1, 16'h0020);
    enable = 1'b1; m_ready = 1'b1;
    observe(8);
    check_eq("emp_rd_cnt", rc, 1);
    check_eq("emp_fwd", {16'd0, fwd_count}, 32'd1);
    check_eq("emp_uferr", {31'd0, underflow_err}, 32'd0);

    // enable drop right after one read
    do_reset();
    load(4, 16'h0030);
    m_ready = 1'b1; enable = 1'b1;
    #1;
    check_eq("en_first_rd", {31'd0, fifo_rd_en}, 32'd1);
    tick();
    enable = 1'b0;
    observe(6);
    check_eq("en_off_rd", rc, 0);
    check_eq("en_off_fwd", {16'd0, fwd_count}, 32'd1);
    enable = 1'b1;
    observe(12);
    check_eq("en_on_fwd", {16'd0, fwd_count}, 32'd4);
    check_eq("en_left", exp_q.size(), 0);

    // Reset mid-stream with buffered and pending words
    do_reset();
    load(6, 16'h0040);
    enable = 1'b1; m_ready = 1'b1;
    observe(3);
    m_ready = 1'b0;
    observe(2);
    check_eq("mid_fwd_pre", {16'd0, fwd_count}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rd_in_rst", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("mid_valid_pre", {31'd0, m_valid}, 32'd1);
    tick();
    check_eq("mid_valid_post", {31'd0, m_valid}, 32'd0);
    check_eq("mid_fwd_post", {16'd0, fwd_count}, 32'd0);
    check_eq("mid_rd_post", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("mid_valid_idle", {31'd0, m_valid}, 32'd0);

    // Randomised enable, backpressure and FIFO writes
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom % 8) != 0;
      m_ready = ($urandom % 4) != 0;
      if (fcnt < 7'd56 && ($urandom % 3) != 0) begin
        wr_req = 1'b1; wr_data = fifo_word_t'($urandom); exp_q.push_back(wr_data);
      end else begin
        wr_req = 1'b0;
      end
      tick();
    end
    wr_req = 1'b0;
    drain(300);
    check_eq("rnd_left", exp_q.size(), 0);

    // Sticky underflow and forwarded-count wrap
    do_reset();
    uf_force = 1'b1;
    tick();
    uf_force = 1'b0;
    tick(); tick();
    check_eq("uf_sticky", {31'd0, underflow_err}, 32'd1);
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      wr_req = 1'b1; wr_data = fifo_word_t'($urandom); exp_q.push_back(wr_data);
      tick();
    end
    wr_req = 1'b0;
    drain(50);
    check_eq("wrap_pre", {16'd0, fwd_count}, 32'h0000_FFFF);
    check_eq("uf_still", {31'd0, underflow_err}, 32'd1);
    put_word(16'hBEEF);
    drain(50);
    check_eq("wrap_post", {16'd0, fwd_count}, 32'd0);
    do_reset();
    check_eq("uf_cleared", {31'd0, underflow_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
